// File: rtl/pcie_flow_fifo.sv
// pcie_flow_fifo: synchronous FIFO for one PCIe switch lane.
// It drives registered status flags for the data-flow controller and
// uses a two-state hysteretic pause machine for back-pressure.
// When the optional macro PCIE_FLOW_FIFO_OCCUPANCY_EN is defined, the
// block adds an `occupancy` output that mirrors the registered count.
module pcie_flow_fifo #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  input  logic                  error_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_pause,
  output logic                  fifo_error
`ifdef PCIE_FLOW_FIFO_OCCUPANCY_EN
  ,
  output logic [ADDR_WIDTH:0]   occupancy
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  typedef enum logic {RUN = 1'b0, PAUSE = 1'b1} pause_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_next;
  logic                  push_ok, pop_ok, err_set;
  pause_t                state, state_next;

  // Decide which requests are accepted, based on the current occupancy.
  // A full FIFO still takes a push when a pop frees a slot in the same cycle.
  always_comb begin
    pop_ok     = pop & (count != '0);
    push_ok    = push & ((count != CNT_W'(DEPTH)) | pop_ok);
    err_set    = (push & ~push_ok) | (pop & ~pop_ok);
    count_next = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // Storage array; it is not reset, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wr_ptr] <= data_in;
  end

  // Pointers, count, read data and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      valid_out    <= 1'b0;
      fifo_full    <= 1'b0;
      fifo_empty   <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      valid_out    <= pop_ok;
      count        <= count_next;
      fifo_full    <= (count_next == CNT_W'(DEPTH));
      fifo_empty   <= (count_next == '0);
      almost_full  <= (count_next >= CNT_W'(AF_THRESH));
      almost_empty <= (count_next <= CNT_W'(AE_THRESH));
    end
  end

  // Sticky error flag; a new error in the same cycle wins over the clear.
  always_ff @(posedge clk) begin
    if (reset)          fifo_error <= 1'b0;
    else if (err_set)   fifo_error <= 1'b1;
    else if (error_clr) fifo_error <= 1'b0;
  end

  // Pause state register.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Hysteresis: set the pause at the high mark and release it at the low mark.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (count_next >= CNT_W'(AF_THRESH)) state_next = PAUSE;
      PAUSE:   if (count_next <= CNT_W'(AE_THRESH)) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign fifo_pause = (state == PAUSE);

`ifdef PCIE_FLOW_FIFO_OCCUPANCY_EN
  // Registered copy of the occupancy for the controller.
  always_ff @(posedge clk) begin
    if (reset) occupancy <= '0;
    else       occupancy <= count_next;
  end
`endif

endmodule

// File: doc/pcie_flow_fifo.md
Name: pcie_flow_fifo

Overview:
- Synchronous FIFO that buffers one PCIe switch lane's data words.
- Generates the status set consumed by the data-flow controller: almost_full, almost_empty, fifo_empty, fifo_full, fifo_error and fifo_pause.
- Sits on the responder side of the controller's write/read handshake. Controller write maps to push; controller read maps to pop.

Parameters:
- DATA_WIDTH, 6: width of data_in and data_out.
- ADDR_WIDTH, 3: pointer width. DEPTH = 2**ADDR_WIDTH = 8 entries.
- AF_THRESH, 6: almost_full and pause-set level. Legal range is AE_THRESH < AF_THRESH < DEPTH.
- AE_THRESH, 2: almost_empty and pause-release level. Legal range is 0 < AE_THRESH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- push  input  1  write request; data_in is captured when the push is accepted.
- data_in  input  DATA_WIDTH  write data.
- pop  input  1  read request.
- error_clr  input  1  clears the sticky fifo_error.
- data_out  output  DATA_WIDTH  registered read data.
- valid_out  output  1  data_out holds a word popped on the previous edge.
- fifo_full  output  1  count == DEPTH.
- fifo_empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- fifo_pause  output  1  hysteretic back-pressure to the controller.
- fifo_error  output  1  sticky overflow/underflow flag.

Behaviour:
- All state is updated on the rising edge of clk. All outputs are registered.
- Reset (reset=1 at an edge, any state, including mid-transfer):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - data_out = 0, valid_out = 0.
  - fifo_empty = 1, almost_empty = 1.
  - fifo_full = 0, almost_full = 0, fifo_pause = 0, fifo_error = 0.
  - Reset overrides push, pop and error_clr in the same cycle.
  - Memory contents are not cleared.
- Accept rules, evaluated on the current count:
  - pop_ok = pop & (count != 0).
  - push_ok = push & ((count != DEPTH) | pop_ok). A full FIFO accepts push together with a simultaneous pop.
  - Empty FIFO with push and pop together: the push is accepted, the pop is rejected.
- Write on push_ok: mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH, natural wrap.
- Read on pop_ok: data_out <= mem[rd_ptr]; rd_ptr increments modulo DEPTH; valid_out = 1 on the next cycle.
  - Read latency is one cycle from the pop edge.
  - No fall-through: a word pushed this edge is poppable from the next edge.
  - If there is no pop_ok, valid_out = 0 and data_out holds its value.
- count_next = count + push_ok - pop_ok. count is ADDR_WIDTH+1 bits wide.
- Status flags are registered from count_next, so they change on the same edge as count:
  - fifo_full = (count_next == DEPTH); fifo_empty = (count_next == 0).
  - almost_full = (count_next >= AF_THRESH); almost_empty = (count_next <= AE_THRESH).
- Pause state machine, two states, same edge as count:
  - RUN (fifo_pause = 0) -> PAUSE when count_next >= AF_THRESH.
  - PAUSE (fifo_pause = 1) -> RUN when count_next <= AE_THRESH.
  - Otherwise the state holds.
- Error:
  - Set to 1 when push & ~push_ok (overflow) or pop & ~pop_ok (underflow).
  - Stays 1 until reset or error_clr.
  - If error_clr and a new error occur in the same cycle, set wins.
  - Rejected operations leave pointers, count and memory unchanged.

Optional Feature:
- Macro: PCIE_FLOW_FIFO_OCCUPANCY_EN.
- When defined:
  - Adds output port occupancy, width ADDR_WIDTH+1, a registered copy of count_next.
  - occupancy resets to 0.
- When undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- Reset: hold reset=1 for 2 cycles, then release -> fifo_empty=1, almost_empty=1, all other flags 0, valid_out=0, data_out=0.
- Fill and pause: push 0x01..0x08 on 8 consecutive cycles ->
  - almost_empty drops after the 3rd push.
  - almost_full and fifo_pause rise after the 6th push.
  - fifo_full rises after the 8th push.
  - fifo_error stays 0.
- Overflow: 9th push with pop=0 -> fifo_error=1, count stays 8. error_clr=1 for one cycle -> fifo_error=0.
- Drain with hysteresis: pop 8 times ->
  - data_out = 0x01..0x08, each one cycle after its pop, with valid_out=1.
  - fifo_pause stays 1 at counts 5..3 and drops when count reaches 2.
  - fifo_empty rises after the 8th pop.
- Underflow and simultaneous ops:
  - pop on empty -> fifo_error=1.
  - push+pop on empty -> count 1, error set.
  - push+pop when full with 0x0A -> count stays 8, fifo_full stays 1, no error.
- Wrap and mid-reset:
  - 20 interleaved push/pop cycles -> FIFO order preserved across pointer wrap.
  - reset asserted at count 5 -> next cycle count 0, fifo_pause=0, fifo_empty=1.
